button_sync_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-button synchroniser.
- Each channel takes a raw asynchronous push-button input and applies, in order: an N-flop synchroniser, a consecutive-sample debounce filter, and a press/release edge-pulse generator.
- Optional auto-repeat emits repeated press pulses while a button is held, e.g. for paddle control.
- Sits between the board button pins and the game-control logic.

---
 rtl/button_pkg.sv | 29 ++
 rtl/button_channel.sv | 189 ++++++++++++++++++
 rtl/button_sync_multi.sv | 38 +++
 tb/tb_button_sync_multi.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the multi-channel button synchroniser.
package button_pkg;

   // Per-channel debounce FSM state, 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMING    = 2'd1,
      HELD      = 2'd2,
      DISARMING = 2'd3
   } btn_state_e;

   // Default parameter values for the top level and each channel.
   localparam int DEF_CHANNELS        = 4;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_EN       = 0;
   localparam int DEF_REPEAT_DELAY    = 32;
   localparam int DEF_REPEAT_PERIOD   = 8;

   // Width of a counter that must hold the largest of the three cycle counts.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debounce FSM, press/release pulses and
// optional auto-repeat of the press pulse while the button is held.
module button_channel
   import button_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_bi,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   btn_state_e             r_state;
   btn_state_e             w_state_next;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_next;
   logic                   w_is_level;
   logic                   w_next_level;
   logic                   w_repeat_fire;
   logic                   w_level_d;
   logic                   w_press_d;
   logic                   w_release_d;
   logic                   r_level;
   logic                   r_press;
   logic                   r_release;

   // Shift chain bringing the asynchronous pin into the clock domain.
   // NOTE: every clocked block uses non-blocking assignments so all flops
   // sample the pre-edge values; blocking here would collapse the chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_bi};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   // FSM state and debounce counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic: count consecutive differing samples, reject glitches.
   // The counter only increments below DB_LAST, so it saturates by construction.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs (no latches).
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (w_s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  w_state_next = HELD;
               end else begin
                  w_state_next = ARMING;
                  w_cnt_next   = CW'(1);
               end
            end
         end
         ARMING: begin
            if (!w_s) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end else if (r_cnt >= DB_LAST) begin
               w_state_next = HELD;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         HELD: begin
            w_cnt_next = '0;
            if (!w_s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  w_state_next = IDLE;
               end else begin
                  w_state_next = DISARMING;
                  w_cnt_next   = CW'(1);
               end
            end
         end
         DISARMING: begin
            if (w_s) begin
               w_state_next = HELD;
               w_cnt_next   = '0;
            end else if (r_cnt >= DB_LAST) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign w_is_level   = (r_state == HELD) || (r_state == DISARMING);
   assign w_next_level = (w_state_next == HELD) || (w_state_next == DISARMING);

   generate
      if (REPEAT_EN != 0) begin : g_repeat
         localparam logic [CW-1:0] REP_DELAY  = CW'(REPEAT_DELAY);
         localparam logic [CW-1:0] REP_PERIOD = CW'(REPEAT_PERIOD);

         logic [CW-1:0] r_rcnt;
         logic          r_rphase;   // 0: waiting initial delay, 1: periodic
         logic [CW-1:0] w_rinc;
         logic [CW-1:0] w_rtarget;
         logic          w_staying;
         logic          w_fire;

         // Repeat timing: counts cycles since the last press pulse while the
         // channel stays in HELD/DISARMING; the target switches after the first repeat.
         always_comb begin
            w_rinc    = r_rcnt + 1'b1;
            w_rtarget = r_rphase ? REP_PERIOD : REP_DELAY;
            w_staying = w_is_level && w_next_level;
            w_fire    = w_staying && (w_rinc >= w_rtarget);
         end

         // Repeat counter; cleared whenever the channel is not continuously held,
         // so a DISARMING glitch back to HELD keeps the running timing.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_rcnt   <= '0;
               r_rphase <= 1'b0;
            end else if (!w_staying) begin
               r_rcnt   <= '0;
               r_rphase <= 1'b0;
            end else if (w_fire) begin
               r_rcnt   <= '0;
               r_rphase <= 1'b1;
            end else begin
               r_rcnt   <= w_rinc;
            end
         end

         assign w_repeat_fire = w_fire;
      end else begin : g_no_repeat
         assign w_repeat_fire = 1'b0;
      end
   endgenerate

   // Output decode from the upcoming state: level, entry/exit edges, repeats.
   always_comb begin
      w_level_d   = w_next_level;
      w_press_d   = (w_next_level && !w_is_level) || w_repeat_fire;
      w_release_d = !w_next_level && w_is_level;
   end

   // Registered outputs, aligned with the state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_level   <= w_level_d;
         r_press   <= w_press_d;
         r_release <= w_release_d;
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;

endmodule

// File: rtl/button_sync_multi.sv
// Multi-channel button front end: CHANNELS independent button_channel copies.
module button_sync_multi
   import button_pkg::*;
#(
   parameter int CHANNELS        = DEF_CHANNELS,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic [CHANNELS-1:0] bi,
   output logic [CHANNELS-1:0] level_o,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o
);

   // One fully independent channel per button pin.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      button_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_EN      (REPEAT_EN),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .i_clk    (Clk),
         .i_rst_n  (Rst_n),
         .i_bi     (bi[g]),
         .o_level  (level_o[g]),
         .o_press  (press_o[g]),
         .o_release(release_o[g])
      );
   end

endmodule

// File: tb/tb_button_sync_multi.sv
// Directed bench for button_sync_multi: 2 channels, 2 sync stages, debounce 4.
// One instance without auto-repeat, one with delay 10 / period 3.
module tb_button_sync_multi;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic [1:0] bi;
   logic [1:0] level_o,   press_o,   release_o;
   logic [1:0] r_level_o, r_press_o, r_release_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] bi;
      logic [1:0] lvl;
      logic [1:0] prs;
      logic [1:0] rel;
   } vec_t;

   vec_t vq[$];

   always #10 Clk = ~Clk;

   button_sync_multi #(
      .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut (
      .Clk(Clk), .Rst_n(Rst_n), .bi(bi),
      .level_o(level_o), .press_o(press_o), .release_o(release_o)
   );

   button_sync_multi #(
      .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut_rep (
      .Clk(Clk), .Rst_n(Rst_n), .bi(bi),
      .level_o(r_level_o), .press_o(r_press_o), .release_o(r_release_o)
   );

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add_n(input int n, input logic [1:0] b, input logic [1:0] l,
                        input logic [1:0] p, input logic [1:0] r);
      vec_t v;
      v.bi = b; v.lvl = l; v.prs = p; v.rel = r;
      for (int k = 0; k < n; k++) vq.push_back(v);
   endtask

   initial begin
      logic [1:0] exp_p;
      logic [1:0] exp_r;

      // Each entry: bi applied before the next edge, outputs checked just after it.
      // Clean press on channel 0: accepted after the 6th edge.
      add_n(5, 2'b01, 2'b00, 2'b00, 2'b00);
      add_n(1, 2'b01, 2'b01, 2'b01, 2'b00);
      add_n(2, 2'b01, 2'b01, 2'b00, 2'b00);
      // Release with bounce 0,1,0: release 6 edges after the final 0 is sampled.
      add_n(1, 2'b00, 2'b01, 2'b00, 2'b00);
      add_n(1, 2'b01, 2'b01, 2'b00, 2'b00);
      add_n(5, 2'b00, 2'b01, 2'b00, 2'b00);
      add_n(1, 2'b00, 2'b00, 2'b00, 2'b01);
      add_n(2, 2'b00, 2'b00, 2'b00, 2'b00);
      // Glitch: 3 cycles high is not accepted.
      add_n(3, 2'b01, 2'b00, 2'b00, 2'b00);
      add_n(7, 2'b00, 2'b00, 2'b00, 2'b00);
      // Simultaneous press on both channels.
      add_n(5, 2'b11, 2'b00, 2'b00, 2'b00);
      add_n(1, 2'b11, 2'b11, 2'b11, 2'b00);
      add_n(2, 2'b11, 2'b11, 2'b00, 2'b00);
      // Release channel 0 while channel 1 stays held.
      add_n(5, 2'b10, 2'b11, 2'b00, 2'b00);
      add_n(1, 2'b10, 2'b10, 2'b00, 2'b01);
      add_n(1, 2'b10, 2'b10, 2'b00, 2'b00);
      // Release channel 1.
      add_n(5, 2'b00, 2'b10, 2'b00, 2'b00);
      add_n(1, 2'b00, 2'b00, 2'b00, 2'b10);
      add_n(1, 2'b00, 2'b00, 2'b00, 2'b00);

      // Power-on reset.
      Rst_n = 1'b0;
      bi    = 2'b00;
      repeat (3) @(posedge Clk);
      #1;
      check("reset level", level_o, 2'b00);
      check("reset press", press_o, 2'b00);
      check("reset release", release_o, 2'b00);
      @(negedge Clk);
      Rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge Clk);
         bi = vq[i].bi;
         @(posedge Clk);
         #1;
         check($sformatf("vec%0d level", i), level_o, vq[i].lvl);
         check($sformatf("vec%0d press", i), press_o, vq[i].prs);
         check($sformatf("vec%0d release", i), release_o, vq[i].rel);
      end

      // Asynchronous reset while both channels are held.
      @(negedge Clk);
      bi = 2'b11;
      repeat (7) @(posedge Clk);
      #1;
      check("held before reset", level_o, 2'b11);
      #4;
      Rst_n = 1'b0;
      #1;
      check("async rst level", level_o, 2'b00);
      check("async rst press", press_o, 2'b00);
      check("async rst release", release_o, 2'b00);
      check("async rst rep level", r_level_o, 2'b00);
      @(posedge Clk);
      #1;
      check("in rst release", release_o, 2'b00);
      @(negedge Clk);
      Rst_n = 1'b1;
      // Held buttons are re-accepted: press on the 6th edge after release.
      for (int e = 1; e <= 8; e++) begin
         @(posedge Clk);
         #1;
         check($sformatf("post-rst e%0d press", e), press_o, (e == 6) ? 2'b11 : 2'b00);
         check($sformatf("post-rst e%0d release", e), release_o, 2'b00);
         check($sformatf("post-rst e%0d level", e), level_o, (e >= 6) ? 2'b11 : 2'b00);
      end

      // Let both channels return to idle.
      @(negedge Clk);
      bi = 2'b00;
      repeat (8) @(posedge Clk);
      #1;
      check("idle before repeat", level_o, 2'b00);
      check("idle before repeat rep", r_level_o, 2'b00);

      // Auto-repeat on channel 1: held for 30 cycles. Accept at edge 6, repeats at
      // 16,19,...,34 (34 falls during DISARMING), release at edge 36.
      for (int e = 1; e <= 40; e++) begin
         @(negedge Clk);
         bi = (e <= 30) ? 2'b10 : 2'b00;
         @(posedge Clk);
         #1;
         exp_p = ((e == 6) || (e >= 16 && e <= 34 && ((e - 16) % 3 == 0))) ? 2'b10 : 2'b00;
         exp_r = (e == 36) ? 2'b10 : 2'b00;
         check($sformatf("rep e%0d press", e), r_press_o, exp_p);
         check($sformatf("rep e%0d release", e), r_release_o, exp_r);
         check($sformatf("norep e%0d press", e), press_o, (e == 6) ? 2'b10 : 2'b00);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
